// File: rtl/tqvp_stevej_wwdt_multi.sv
`default_nettype none
// ============================================================================
// Module   : tqvp_stevej_wwdt_multi
// Purpose  : Multi-channel windowed watchdog for the TinyQV peripheral bus.
//            Each channel counts prescaler ticks through a CLOSED window
//            (pats are early) and an OPEN window (pats are accepted). It
//            expires when the count reaches WIN_CLOSE without a pat.
//            Faults are sticky write-1-to-clear flags. A per-channel mask
//            lets a flag drive the shared interrupt.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk            in   clock
//   rst_n          in   synchronous active-low reset
//   ui_in[7:0]     in   input PMOD, readable at 0x32
//   uo_out[7:0]    out  [3:0] channel expired, [7:4] channel enabled
//   address[5:0]   in   register address (channel c at c*8, globals at 0x30+)
//   data_in[31:0]  in   write data
//   data_write_n   in   2'b11 = idle, anything else = write
//   data_read_n    in   unused
//   data_out[31:0] out  combinational read data
//   data_ready     out  always 1
//   user_interrupt out  OR of (IRQ_EN & any sticky fault) over channels
// ============================================================================
module tqvp_stevej_wwdt_multi #(
  parameter int         NUM_CH  = 2,
  parameter int         CNT_W   = 24,
  parameter int         PRE_W   = 8,
  parameter logic [7:0] PAT_KEY = 8'h5A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLOSED  = 2'd1,
    ST_OPEN    = 2'd2,
    ST_EXPIRED = 2'd3
  } ch_state_e;

  localparam logic [5:0] ADDR_PRESCALE = 6'h30;
  localparam logic [5:0] ADDR_IRQ_SUM  = 6'h31;
  localparam logic [5:0] ADDR_UI_IN    = 6'h32;

  logic wr_en;
  assign wr_en      = (data_write_n != 2'b11);
  assign data_ready = 1'b1;

  // --------------------------------------------------------------------------
  // Shared prescaler: one tick every PRESCALE+1 cycles.
  // --------------------------------------------------------------------------
  logic [PRE_W-1:0] prescale_q, prescale_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic             tick;
  logic             wr_prescale;

  assign wr_prescale = wr_en && (address == ADDR_PRESCALE);

  always_comb begin
    prescale_d = prescale_q;
    pre_cnt_d  = pre_cnt_q + PRE_W'(1);
    tick       = (pre_cnt_q == prescale_q);
    if (wr_prescale) begin
      prescale_d = data_in[PRE_W-1:0];
    end
    // A new prescale value restarts the period from zero.
    if (wr_prescale || tick) begin
      pre_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescale_q <= '0;
      pre_cnt_q  <= '0;
    end else begin
      prescale_q <= prescale_d;
      pre_cnt_q  <= pre_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Channels
  // --------------------------------------------------------------------------
  logic [NUM_CH-1:0]       expired_vec;
  logic [NUM_CH-1:0]       enabled_vec;
  logic [NUM_CH-1:0]       fault_vec;
  logic [NUM_CH-1:0]       irq_vec;
  logic [NUM_CH-1:0][31:0] ch_rd;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [2:0] CH_IDX = 3'(c);

    ch_state_e        state_q, state_d;
    logic [2:0]       ctrl_q, ctrl_d;         // [0] EN, [1] LOCK, [2] IRQ_EN
    logic [CNT_W-1:0] win_open_q, win_open_d;
    logic [CNT_W-1:0] win_close_q, win_close_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       flags_q, flags_d;       // [0] EARLY, [1] LATE, [2] KEYERR

    logic             hit;
    logic             locked;
    logic             ctrl_wr, pat_wr, st_wr;
    logic             ctrl_takes;
    logic             pat_valid;
    logic             at_close;
    logic [CNT_W-1:0] cnt_inc;
    logic [2:0]       set_flags;
    logic             running;
    logic [31:0]      rd;

    assign hit     = wr_en && (address[5:3] == CH_IDX);
    assign locked  = ctrl_q[1] & ctrl_q[0];
    assign ctrl_wr = hit && (address[2:0] == 3'd0) && !locked;
    assign pat_wr  = hit && (address[2:0] == 3'd3);
    assign st_wr   = hit && (address[2:0] == 3'd4);
    assign running = (state_q == ST_CLOSED) || (state_q == ST_OPEN);

    always_comb begin
      state_d     = state_q;
      ctrl_d      = ctrl_q;
      win_open_d  = win_open_q;
      win_close_d = win_close_q;
      count_d     = count_q;
      set_flags   = 3'b000;
      cnt_inc     = count_q + CNT_W'(1);
      // >= rather than == so that a window shrunk below the live count still
      // expires instead of letting the counter run on and wrap.
      at_close    = (count_q >= win_close_q) || (count_q == {CNT_W{1'b1}});
      pat_valid   = pat_wr && (data_in[7:0] == PAT_KEY) && running;
      ctrl_takes  = ctrl_wr && (!data_in[0] || (state_q == ST_IDLE));

      if (hit && !locked && (address[2:0] == 3'd1)) begin
        win_open_d = data_in[CNT_W-1:0];
      end
      if (hit && !locked && (address[2:0] == 3'd2)) begin
        win_close_d = data_in[CNT_W-1:0];
      end
      if (ctrl_wr) begin
        ctrl_d = data_in[2:0];
      end

      if (pat_wr && (data_in[7:0] != PAT_KEY)) begin
        set_flags[2] = 1'b1;
      end

      if (ctrl_takes) begin
        // Disable, or start from IDLE: either way the count restarts at zero.
        state_d = data_in[0] ? ST_CLOSED : ST_IDLE;
        count_d = '0;
      end else if (pat_valid) begin
        // A pat beats a coincident tick, so it can rescue the last cycle.
        count_d = '0;
        state_d = ST_CLOSED;
        if (state_q == ST_CLOSED) begin
          set_flags[0] = 1'b1;
        end
      end else if (tick && running) begin
        if (at_close) begin
          state_d      = ST_EXPIRED;
          set_flags[1] = 1'b1;
        end else begin
          count_d = cnt_inc;
          if ((state_q == ST_CLOSED) && (cnt_inc > win_open_q)) begin
            state_d = ST_OPEN;
          end
        end
      end

      // Setting a fault has priority over clearing it in the same cycle.
      flags_d = (flags_q & ~(st_wr ? data_in[2:0] : 3'b000)) | set_flags;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q     <= ST_IDLE;
        ctrl_q      <= '0;
        win_open_q  <= '0;
        win_close_q <= '0;
        count_q     <= '0;
        flags_q     <= '0;
      end else begin
        state_q     <= state_d;
        ctrl_q      <= ctrl_d;
        win_open_q  <= win_open_d;
        win_close_q <= win_close_d;
        count_q     <= count_d;
        flags_q     <= flags_d;
      end
    end

    always_comb begin
      rd = '0;
      if (address[5:3] == CH_IDX) begin
        case (address[2:0])
          3'd0:    rd[2:0]       = ctrl_q;
          3'd1:    rd[CNT_W-1:0] = win_open_q;
          3'd2:    rd[CNT_W-1:0] = win_close_q;
          3'd4:    rd[3:0]       = {running, flags_q};
          3'd5:    rd[CNT_W-1:0] = count_q;
          default: rd            = '0;
        endcase
      end
    end

    assign ch_rd[c]       = rd;
    assign expired_vec[c] = (state_q == ST_EXPIRED);
    assign enabled_vec[c] = ctrl_q[0];
    assign fault_vec[c]   = |flags_q;
    assign irq_vec[c]     = ctrl_q[2] & (|flags_q);
  end

  // --------------------------------------------------------------------------
  // Outputs and read mux
  // --------------------------------------------------------------------------
  logic [3:0] expired4, enabled4;

  always_comb begin
    expired4               = '0;
    enabled4               = '0;
    expired4[NUM_CH-1:0]   = expired_vec;
    enabled4[NUM_CH-1:0]   = enabled_vec;
  end

  assign uo_out         = {enabled4, expired4};
  assign user_interrupt = |irq_vec;

  always_comb begin
    data_out = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      data_out = data_out | ch_rd[c];
    end
    case (address)
      ADDR_PRESCALE: data_out[PRE_W-1:0]  = prescale_q;
      ADDR_IRQ_SUM:  data_out[NUM_CH-1:0] = fault_vec;
      ADDR_UI_IN:    data_out[7:0]        = ui_in;
      default:       ;
    endcase
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, data_read_n, data_in};

endmodule

`default_nettype wire

// File: tb/tb_tqvp_stevej_wwdt_multi.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// Module   : tb_tqvp_stevej_wwdt_multi
// Purpose  : Directed self-checking bench for tqvp_stevej_wwdt_multi with
//            hand-computed expected register, uo_out and interrupt values.
// Revision : 1.0  initial release
// ============================================================================
module tb_tqvp_stevej_wwdt_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ui_in;
  logic [7:0]  uo_out;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  int n_checks = 0;
  int n_errors = 0;

  tqvp_stevej_wwdt_multi dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ui_in          (ui_in),
    .uo_out         (uo_out),
    .address        (address),
    .data_in        (data_in),
    .data_write_n   (data_write_n),
    .data_read_n    (data_read_n),
    .data_out       (data_out),
    .data_ready     (data_ready),
    .user_interrupt (user_interrupt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    address      = a;
    data_in      = d;
    data_write_n = 2'b00;
    @(posedge clk);
    #1;
    data_write_n = 2'b11;
    data_in      = '0;
  endtask

  task automatic chk_reg(input string tag, input logic [5:0] a, input logic [31:0] exp);
    address = a;
    #0.1;
    check(tag, data_out, exp);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n        = 1'b0;
    ui_in        = 8'hA7;
    address      = '0;
    data_in      = '0;
    data_write_n = 2'b11;
    data_read_n  = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    check("rst_uo", {24'h0, uo_out}, 32'h0);
    check("rst_irq", {31'h0, user_interrupt}, 32'h0);
    check("rst_ready", {31'h0, data_ready}, 32'h1);
    chk_reg("rst_ctrl0", 6'h00, 32'h0);
    chk_reg("rst_status0", 6'h04, 32'h0);
    chk_reg("rst_count0", 6'h05, 32'h0);
    chk_reg("rst_prescale", 6'h30, 32'h0);
    chk_reg("ui_in_rd", 6'h32, 32'hA7);

    // 1: late expiry after 11 ticks
    wr(6'h01, 32'd4);
    wr(6'h02, 32'd10);
    wr(6'h00, 32'h5);
    chk_reg("t1_cnt0", 6'h05, 32'd0);
    step(3);
    chk_reg("t1_cnt3", 6'h05, 32'd3);
    chk_reg("t1_run", 6'h04, 32'h8);
    step(7);
    chk_reg("t1_cnt10", 6'h05, 32'd10);
    check("t1_uo_pre", {24'h0, uo_out}, 32'h10);
    check("t1_irq_pre", {31'h0, user_interrupt}, 32'h0);
    step(1);
    check("t1_uo_exp", {24'h0, uo_out}, 32'h11);
    chk_reg("t1_status", 6'h04, 32'h2);
    chk_reg("t1_cnt_hold", 6'h05, 32'd10);
    chk_reg("t1_irqsum", 6'h31, 32'h1);
    check("t1_irq", {31'h0, user_interrupt}, 32'h1);
    wr(6'h04, 32'h2);
    chk_reg("t1_w1c", 6'h04, 32'h0);
    check("t1_irq_clr", {31'h0, user_interrupt}, 32'h0);
    check("t1_uo_still", {24'h0, uo_out}, 32'h11);

    // 2: early pat, then in-window pat
    wr(6'h00, 32'h0);
    check("t2_uo_idle", {24'h0, uo_out}, 32'h0);
    chk_reg("t2_cnt_idle", 6'h05, 32'd0);
    wr(6'h00, 32'h5);
    step(2);
    chk_reg("t2_cnt2", 6'h05, 32'd2);
    wr(6'h03, 32'h5A);
    chk_reg("t2_early_cnt", 6'h05, 32'd0);
    chk_reg("t2_early_st", 6'h04, 32'h9);
    check("t2_irq", {31'h0, user_interrupt}, 32'h1);
    step(7);
    chk_reg("t2_cnt7", 6'h05, 32'd7);
    wr(6'h03, 32'h5A);
    chk_reg("t2_pat_cnt", 6'h05, 32'd0);
    chk_reg("t2_pat_st", 6'h04, 32'h9);
    wr(6'h04, 32'h7);
    chk_reg("t2_clr_st", 6'h04, 32'h8);
    wr(6'h03, 32'h5A);
    chk_reg("t2_closed_again", 6'h04, 32'h9);
    wr(6'h04, 32'h1);

    // 3: bad key, masked interrupt
    wr(6'h00, 32'h0);
    wr(6'h04, 32'h7);
    wr(6'h30, 32'd200);
    wr(6'h00, 32'h1);
    wr(6'h03, 32'hA5);
    chk_reg("t3_keyerr", 6'h04, 32'hC);
    chk_reg("t3_cnt", 6'h05, 32'd0);
    check("t3_irq_masked", {31'h0, user_interrupt}, 32'h0);
    chk_reg("t3_irqsum", 6'h31, 32'h1);
    wr(6'h00, 32'h5);
    check("t3_irq_unmask", {31'h0, user_interrupt}, 32'h1);
    wr(6'h04, 32'h4);
    chk_reg("t3_clr", 6'h04, 32'h8);
    check("t3_irq_clr", {31'h0, user_interrupt}, 32'h0);

    // 4: lock
    wr(6'h00, 32'h0);
    wr(6'h30, 32'd0);
    wr(6'h00, 32'h3);
    wr(6'h00, 32'h0);
    wr(6'h02, 32'd99);
    chk_reg("t4_ctrl", 6'h00, 32'h3);
    chk_reg("t4_wclose", 6'h02, 32'd10);
    step(8);
    chk_reg("t4_cnt10", 6'h05, 32'd10);
    check("t4_uo_pre", {24'h0, uo_out}, 32'h10);
    step(1);
    check("t4_uo_exp", {24'h0, uo_out}, 32'h11);
    chk_reg("t4_status", 6'h04, 32'h2);
    check("t4_irq_off", {31'h0, user_interrupt}, 32'h0);
    pulse_reset();
    check("t4_rst_uo", {24'h0, uo_out}, 32'h0);
    chk_reg("t4_rst_ctrl", 6'h00, 32'h0);
    chk_reg("t4_rst_wclose", 6'h02, 32'h0);
    chk_reg("t4_rst_st", 6'h04, 32'h0);

    // 5: prescale 3, two channels
    wr(6'h01, 32'd4);
    wr(6'h02, 32'd10);
    wr(6'h09, 32'd1);
    wr(6'h0A, 32'd2);
    wr(6'h30, 32'd3);
    wr(6'h00, 32'h1);
    wr(6'h08, 32'h1);
    step(1);
    chk_reg("t5_cnt0", 6'h05, 32'd0);
    step(1);
    chk_reg("t5_ch0_1", 6'h05, 32'd1);
    chk_reg("t5_ch1_1", 6'h0D, 32'd1);
    step(3);
    chk_reg("t5_ch0_hold", 6'h05, 32'd1);
    step(1);
    chk_reg("t5_ch0_2", 6'h05, 32'd2);
    step(4);
    check("t5_uo", {24'h0, uo_out}, 32'h32);
    chk_reg("t5_ch1_st", 6'h0C, 32'h2);
    chk_reg("t5_ch1_cnt", 6'h0D, 32'd2);
    chk_reg("t5_ch0_3", 6'h05, 32'd3);
    chk_reg("t5_ch0_st", 6'h04, 32'h8);
    step(4);
    chk_reg("t5_ch0_4", 6'h05, 32'd4);
    wr(6'h10, 32'h5);
    chk_reg("t5_absent", 6'h10, 32'h0);
    chk_reg("t5_prescale", 6'h30, 32'd3);

    // 6: pat coincident with the expiring tick
    pulse_reset();
    wr(6'h01, 32'd4);
    wr(6'h02, 32'd10);
    wr(6'h00, 32'h5);
    step(10);
    chk_reg("t6_cnt10", 6'h05, 32'd10);
    wr(6'h03, 32'h5A);
    chk_reg("t6_cnt0", 6'h05, 32'd0);
    chk_reg("t6_st", 6'h04, 32'h8);
    check("t6_uo", {24'h0, uo_out}, 32'h10);
    step(1);
    chk_reg("t6_cnt1", 6'h05, 32'd1);

    // Inverted window: every pat is early, expires straight from CLOSED
    wr(6'h09, 32'd5);
    wr(6'h0A, 32'd3);
    wr(6'h08, 32'h1);
    wr(6'h0B, 32'h5A);
    chk_reg("t7_early", 6'h0C, 32'h9);
    step(3);
    chk_reg("t7_cnt3", 6'h0D, 32'd3);
    step(1);
    chk_reg("t7_st", 6'h0C, 32'h3);
    check("t7_uo", {24'h0, uo_out}, 32'h32);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
